// File: rtl/axi_request_queue_if.sv
// Core-side request/response and master-side issue/completion signals
// of the AXI request queue, bundled for one port.
interface axi_request_queue_if;
    logic        wr_req_valid_i;
    logic        wr_req_ready_o;
    logic [31:0] wr_req_address_i;
    logic [31:0] wr_req_data_i;
    logic [3:0]  wr_req_strobe_i;
    logic        wr_ack_o;
    logic        wr_error_o;
    logic        rd_req_valid_i;
    logic        rd_req_ready_o;
    logic [31:0] rd_req_address_i;
    logic        rd_valid_o;
    logic [31:0] rd_data_o;
    logic        rd_error_o;
    logic [31:0] write_address_o;
    logic [31:0] write_data_o;
    logic [3:0]  write_strobe_o;
    logic        write_start_o;
    logic        write_cts_i;
    logic        write_done_i;
    logic [1:0]  write_response_i;
    logic [31:0] read_address_o;
    logic        read_start_o;
    logic        read_cts_i;
    logic        read_done_i;
    logic [31:0] read_data_i;
    logic [1:0]  read_response_i;
    logic        idle_o;

    modport slave (
        input  wr_req_valid_i, wr_req_address_i, wr_req_data_i,
        input  wr_req_strobe_i,
        output wr_req_ready_o, wr_ack_o, wr_error_o,
        input  rd_req_valid_i, rd_req_address_i,
        output rd_req_ready_o, rd_valid_o, rd_data_o, rd_error_o,
        output write_address_o, write_data_o, write_strobe_o,
        output write_start_o,
        input  write_cts_i, write_done_i, write_response_i,
        output read_address_o, read_start_o,
        input  read_cts_i, read_done_i, read_data_i, read_response_i,
        output idle_o
    );

    modport master (
        output wr_req_valid_i, wr_req_address_i, wr_req_data_i,
        output wr_req_strobe_i,
        input  wr_req_ready_o, wr_ack_o, wr_error_o,
        output rd_req_valid_i, rd_req_address_i,
        input  rd_req_ready_o, rd_valid_o, rd_data_o, rd_error_o,
        input  write_address_o, write_data_o, write_strobe_o,
        input  write_start_o,
        output write_cts_i, write_done_i, write_response_i,
        input  read_address_o, read_start_o,
        output read_cts_i, read_done_i, read_data_i, read_response_i,
        input  idle_o
    );
endinterface

// File: rtl/axi_request_queue.sv
// Write/read request FIFOs in front of the AXI master with an
// outstanding-transaction limit and SLVERR-triggered queue flush.
module axi_request_queue #(
    parameter int WR_DEPTH        = 8,
    parameter int RD_DEPTH        = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic                  clk_i,
    input logic                  rst_i,
    axi_request_queue_if.slave   bus
);

    localparam int WA = $clog2(WR_DEPTH);
    localparam int RA = $clog2(RD_DEPTH);
    localparam logic [3:0] MAX_OS = 4'(MAX_OUTSTANDING);
    localparam logic [1:0] SLVERR = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strobe;
    } wr_entry_t;

    wr_entry_t   wr_mem_q [WR_DEPTH];
    logic [31:0] rd_mem_q [RD_DEPTH];

    logic [WA:0] wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
    logic [RA:0] rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
    logic [3:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic        wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
    logic        rd_vld_q, rd_vld_d, rd_err_q, rd_err_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic wr_full, wr_empty, wr_flush, wr_ready, wr_push, wr_issue;
    logic rd_full, rd_empty, rd_flush, rd_ready, rd_push, rd_issue;
    logic wr_dec, rd_dec;

    always_comb begin
        wr_empty = wr_wptr_q == wr_rptr_q;
        wr_full  = (wr_wptr_q[WA-1:0] == wr_rptr_q[WA-1:0]) &&
                   (wr_wptr_q[WA] != wr_rptr_q[WA]);
        wr_flush = bus.write_done_i && (bus.write_response_i == SLVERR);
        wr_ready = !wr_full && !wr_flush && !rst_i;
        wr_push  = bus.wr_req_valid_i && wr_ready;
        wr_issue = !wr_empty && bus.write_cts_i && (wr_cnt_q < MAX_OS) &&
                   !wr_flush && !rst_i;
        // Completions with nothing outstanding are stale; drop them.
        wr_dec   = bus.write_done_i && (wr_cnt_q != 4'd0);
        wr_cnt_d = wr_cnt_q + {3'b0, wr_issue} - {3'b0, wr_dec};
        wr_wptr_d = wr_wptr_q + (WA+1)'(wr_push);
        wr_rptr_d = wr_rptr_q + (WA+1)'(wr_issue);
        if (wr_flush) begin
            wr_wptr_d = '0;
            wr_rptr_d = '0;
        end
        wr_ack_d = bus.write_done_i;
        wr_err_d = wr_flush;
    end

    always_comb begin
        rd_empty = rd_wptr_q == rd_rptr_q;
        rd_full  = (rd_wptr_q[RA-1:0] == rd_rptr_q[RA-1:0]) &&
                   (rd_wptr_q[RA] != rd_rptr_q[RA]);
        rd_flush = bus.read_done_i && (bus.read_response_i == SLVERR);
        rd_ready = !rd_full && !rd_flush && !rst_i;
        rd_push  = bus.rd_req_valid_i && rd_ready;
        rd_issue = !rd_empty && bus.read_cts_i && (rd_cnt_q < MAX_OS) &&
                   !rd_flush && !rst_i;
        rd_dec   = bus.read_done_i && (rd_cnt_q != 4'd0);
        rd_cnt_d = rd_cnt_q + {3'b0, rd_issue} - {3'b0, rd_dec};
        rd_wptr_d = rd_wptr_q + (RA+1)'(rd_push);
        rd_rptr_d = rd_rptr_q + (RA+1)'(rd_issue);
        if (rd_flush) begin
            rd_wptr_d = '0;
            rd_rptr_d = '0;
        end
        rd_vld_d  = bus.read_done_i;
        rd_err_d  = rd_flush;
        rd_data_d = bus.read_done_i ? bus.read_data_i : rd_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_wptr_q <= '0;
            wr_rptr_q <= '0;
            wr_cnt_q  <= '0;
            wr_ack_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            rd_wptr_q <= '0;
            rd_rptr_q <= '0;
            rd_cnt_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_wptr_q <= wr_wptr_d;
            wr_rptr_q <= wr_rptr_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_ack_q  <= wr_ack_d;
            wr_err_q  <= wr_err_d;
            rd_wptr_q <= rd_wptr_d;
            rd_rptr_q <= rd_rptr_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_vld_q  <= rd_vld_d;
            rd_err_q  <= rd_err_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_push) begin
            wr_mem_q[wr_wptr_q[WA-1:0]] <= '{
                addr:   bus.wr_req_address_i,
                data:   bus.wr_req_data_i,
                strobe: bus.wr_req_strobe_i
            };
        end
        if (rd_push) begin
            rd_mem_q[rd_wptr_q[RA-1:0]] <= bus.rd_req_address_i;
        end
    end

    assign bus.wr_req_ready_o  = wr_ready;
    assign bus.rd_req_ready_o  = rd_ready;
    assign bus.write_start_o   = wr_issue;
    assign bus.read_start_o    = rd_issue;
    assign bus.write_address_o = wr_mem_q[wr_rptr_q[WA-1:0]].addr;
    assign bus.write_data_o    = wr_mem_q[wr_rptr_q[WA-1:0]].data;
    assign bus.write_strobe_o  = wr_mem_q[wr_rptr_q[WA-1:0]].strobe;
    assign bus.read_address_o  = rd_mem_q[rd_rptr_q[RA-1:0]];
    assign bus.wr_ack_o        = wr_ack_q;
    assign bus.wr_error_o      = wr_err_q;
    assign bus.rd_valid_o      = rd_vld_q;
    assign bus.rd_error_o      = rd_err_q;
    assign bus.rd_data_o       = rd_data_q;
    assign bus.idle_o = rst_i || (wr_empty && rd_empty &&
                        (wr_cnt_q == 4'd0) && (rd_cnt_q == 4'd0));

endmodule

// File: tb/tb_axi_request_queue.sv
// Bench for axi_request_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_axi_request_queue;

    localparam int WR_DEPTH = 8;
    localparam int RD_DEPTH = 8;
    localparam int MAXO     = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } went_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_request_queue_if bus();

    axi_request_queue #(
        .WR_DEPTH(WR_DEPTH),
        .RD_DEPTH(RD_DEPTH),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    went_t       wq[$];
    logic [31:0] rq[$];
    int          wout = 0;
    int          rout = 0;

    logic e_wready, e_wstart, e_rready, e_rstart, e_idle;
    logic e_wack = 1'b0, e_werr = 1'b0, e_rvalid = 1'b0, e_rerr = 1'b0;
    logic [31:0] e_rdata = '0;
    went_t       e_whead;
    logic [31:0] e_rhead;

    task automatic idle_inputs();
        bus.wr_req_valid_i   = 1'b0;
        bus.wr_req_address_i = '0;
        bus.wr_req_data_i    = '0;
        bus.wr_req_strobe_i  = '0;
        bus.rd_req_valid_i   = 1'b0;
        bus.rd_req_address_i = '0;
        bus.write_cts_i      = 1'b0;
        bus.write_done_i     = 1'b0;
        bus.write_response_i = 2'b00;
        bus.read_cts_i       = 1'b0;
        bus.read_done_i      = 1'b0;
        bus.read_data_i      = '0;
        bus.read_response_i  = 2'b00;
    endtask

    // Expected combinational outputs for the inputs currently applied.
    task automatic model_eval();
        logic wfl, rfl;
        wfl = bus.write_done_i && (bus.write_response_i == 2'b10);
        rfl = bus.read_done_i && (bus.read_response_i == 2'b10);
        if (rst) begin
            e_wready = 1'b0;
            e_rready = 1'b0;
            e_wstart = 1'b0;
            e_rstart = 1'b0;
            e_idle   = 1'b1;
        end else begin
            e_wready = (wq.size() < WR_DEPTH) && !wfl;
            e_rready = (rq.size() < RD_DEPTH) && !rfl;
            e_wstart = (wq.size() != 0) && bus.write_cts_i &&
                       (wout < MAXO) && !wfl;
            e_rstart = (rq.size() != 0) && bus.read_cts_i &&
                       (rout < MAXO) && !rfl;
            e_idle   = (wq.size() == 0) && (rq.size() == 0) &&
                       (wout == 0) && (rout == 0);
        end
        if (wq.size() != 0) e_whead = wq[0];
        if (rq.size() != 0) e_rhead = rq[0];
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    // Clock edge: advance the model with the inputs applied this cycle.
    task automatic advance();
        went_t went;
        logic wv, rv, wd, rd, wfl, rfl, ws, rs, wr, rr;
        logic [31:0] ra, rdat;
        int wold, rold;
        model_eval();
        wv   = bus.wr_req_valid_i;
        rv   = bus.rd_req_valid_i;
        wd   = bus.write_done_i;
        rd   = bus.read_done_i;
        wfl  = wd && (bus.write_response_i == 2'b10);
        rfl  = rd && (bus.read_response_i == 2'b10);
        went = '{a: bus.wr_req_address_i, d: bus.wr_req_data_i,
                 s: bus.wr_req_strobe_i};
        ra   = bus.rd_req_address_i;
        rdat = bus.read_data_i;
        ws = e_wstart; rs = e_rstart; wr = e_wready; rr = e_rready;
        @(posedge clk);
        if (rst) begin
            wq.delete();
            rq.delete();
            wout = 0;
            rout = 0;
            e_wack = 1'b0; e_werr = 1'b0;
            e_rvalid = 1'b0; e_rerr = 1'b0;
        end else begin
            if (wfl) wq.delete();
            else begin
                if (ws) void'(wq.pop_front());
                if (wv && wr) wq.push_back(went);
            end
            if (rfl) rq.delete();
            else begin
                if (rs) void'(rq.pop_front());
                if (rv && rr) rq.push_back(ra);
            end
            wold = wout;
            rold = rout;
            wout = wold + (ws ? 1 : 0) - ((wd && wold > 0) ? 1 : 0);
            rout = rold + (rs ? 1 : 0) - ((rd && rold > 0) ? 1 : 0);
            e_wack = wd; e_werr = wfl;
            e_rvalid = rd; e_rerr = rfl;
            if (rd) e_rdata = rdat;
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.wr_req_valid_i = 1'b1;
        bus.rd_req_valid_i = 1'b1;
        bus.write_cts_i    = 1'b1;
        bus.read_cts_i     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            advance();
            settle();
            n_vec += 4;
            if (bus.wr_req_ready_o !== 1'b0 || bus.rd_req_ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_ready: got %b%b want 00",
                         bus.wr_req_ready_o, bus.rd_req_ready_o);
            end
            if (bus.write_start_o !== 1'b0 || bus.read_start_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_start: got %b%b want 00",
                         bus.write_start_o, bus.read_start_o);
            end
            if (bus.idle_o !== 1'b1) begin
                n_err++;
                $display("FAIL reset_idle: got %b want 1", bus.idle_o);
            end
            if (bus.wr_ack_o !== 1'b0 || bus.rd_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_ack: got %b%b want 00",
                         bus.wr_ack_o, bus.rd_valid_o);
            end
        end
        advance();
        rst = 1'b0;
        idle_inputs();
        settle();
        n_vec += 3;
        if (bus.wr_req_ready_o !== 1'b1 || bus.rd_req_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL release_ready: got %b%b want 11",
                     bus.wr_req_ready_o, bus.rd_req_ready_o);
        end
        if (bus.idle_o !== 1'b1) begin
            n_err++;
            $display("FAIL release_idle: got %b want 1", bus.idle_o);
        end
        if (bus.wr_ack_o !== 1'b0 || bus.rd_valid_o !== 1'b0 ||
            bus.write_start_o !== 1'b0 || bus.read_start_o !== 1'b0) begin
            n_err++;
            $display("FAIL release_outs: got %b%b%b%b want 0000",
                     bus.wr_ack_o, bus.rd_valid_o,
                     bus.write_start_o, bus.read_start_o);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        went_t exp [3];
        bit    done_at [32];
        int    pushed = 0, starts = 0, acks = 0;
        exp[0] = '{a: 32'h10, d: 32'hA, s: 4'hF};
        exp[1] = '{a: 32'h14, d: 32'hB, s: 4'hF};
        exp[2] = '{a: 32'h18, d: 32'hC, s: 4'hF};
        foreach (done_at[i]) done_at[i] = 1'b0;
        idle_inputs();
        bus.write_cts_i = 1'b1;
        for (int c = 0; c < 16; c++) begin
            bus.wr_req_valid_i = pushed < 3;
            if (pushed < 3) begin
                bus.wr_req_address_i = exp[pushed].a;
                bus.wr_req_data_i    = exp[pushed].d;
                bus.wr_req_strobe_i  = exp[pushed].s;
            end
            bus.write_done_i = done_at[c];
            settle();
            n_vec += 2;
            if (bus.write_start_o !== e_wstart) begin
                n_err++;
                $display("FAIL b2b_start c%0d: got %b want %b",
                         c, bus.write_start_o, e_wstart);
            end
            if (bus.write_start_o === 1'b1) begin
                n_vec++;
                if (starts >= 3) begin
                    n_err++;
                    $display("FAIL b2b_extra_start: got %0d want 3", starts + 1);
                end else if ({bus.write_address_o, bus.write_data_o,
                              bus.write_strobe_o} !== exp[starts]) begin
                    n_err++;
                    $display("FAIL b2b_head #%0d: got %h/%h/%h want %h",
                             starts, bus.write_address_o, bus.write_data_o,
                             bus.write_strobe_o, exp[starts]);
                end
                done_at[c+2] = 1'b1;
                starts++;
            end
            if (bus.wr_ack_o !== e_wack) begin
                n_err++;
                $display("FAIL b2b_ack c%0d: got %b want %b",
                         c, bus.wr_ack_o, e_wack);
            end
            if (bus.wr_ack_o === 1'b1) begin
                acks++;
                n_vec++;
                if (bus.wr_error_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_err: got %b want 0", bus.wr_error_o);
                end
            end
            if (bus.wr_req_valid_i && bus.wr_req_ready_o) pushed++;
            advance();
        end
        n_vec++;
        if (starts != 3 || acks != 3) begin
            n_err++;
            $display("FAIL b2b_counts: got %0d starts %0d acks want 3 3",
                     starts, acks);
        end
    endtask

    task automatic test_fill();
        went_t exp [9];
        bit    done_at [64];
        int    pushed = 0, starts = 0;
        for (int i = 0; i < 9; i++)
            exp[i] = '{a: 32'h1000 + 32'(i * 4), d: $urandom,
                       s: 4'($urandom_range(0, 15))};
        foreach (done_at[i]) done_at[i] = 1'b0;
        idle_inputs();
        for (int c = 0; c < 40; c++) begin
            bus.write_cts_i    = c >= 10;
            bus.wr_req_valid_i = pushed < 9;
            if (pushed < 9) begin
                bus.wr_req_address_i = exp[pushed].a;
                bus.wr_req_data_i    = exp[pushed].d;
                bus.wr_req_strobe_i  = exp[pushed].s;
            end
            bus.write_done_i = done_at[c];
            settle();
            n_vec += 2;
            if (bus.wr_req_ready_o !== e_wready) begin
                n_err++;
                $display("FAIL fill_ready c%0d: got %b want %b",
                         c, bus.wr_req_ready_o, e_wready);
            end
            if (bus.write_start_o !== e_wstart) begin
                n_err++;
                $display("FAIL fill_start c%0d: got %b want %b",
                         c, bus.write_start_o, e_wstart);
            end
            if (pushed == WR_DEPTH && c < 11) begin
                n_vec++;
                if (bus.wr_req_ready_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL fill_full c%0d: got %b want 0",
                             c, bus.wr_req_ready_o);
                end
            end
            if (bus.write_start_o === 1'b1) begin
                n_vec++;
                if (starts >= 9) begin
                    n_err++;
                    $display("FAIL fill_extra_start: got %0d want 9", starts + 1);
                end else if ({bus.write_address_o, bus.write_data_o,
                              bus.write_strobe_o} !== exp[starts]) begin
                    n_err++;
                    $display("FAIL fill_order #%0d: got %h want %h",
                             starts, bus.write_address_o, exp[starts].a);
                end
                done_at[c+2] = 1'b1;
                starts++;
            end
            if (bus.wr_req_valid_i && bus.wr_req_ready_o) pushed++;
            advance();
        end
        settle();
        n_vec += 2;
        if (starts != 9 || pushed != 9) begin
            n_err++;
            $display("FAIL fill_counts: got %0d starts %0d pushes want 9 9",
                     starts, pushed);
        end
        if (bus.idle_o !== 1'b1) begin
            n_err++;
            $display("FAIL fill_idle: got %b want 1", bus.idle_o);
        end
    endtask

    task automatic test_outstanding();
        int starts = 0;
        idle_inputs();
        bus.read_cts_i = 1'b1;
        for (int c = 0; c < 14; c++) begin
            bus.rd_req_valid_i   = c < 6;
            bus.rd_req_address_i = 32'h2000 + 32'(c * 4);
            settle();
            n_vec++;
            if (bus.read_start_o !== e_rstart) begin
                n_err++;
                $display("FAIL os_start c%0d: got %b want %b",
                         c, bus.read_start_o, e_rstart);
            end
            if (bus.read_start_o === 1'b1) starts++;
            advance();
        end
        bus.rd_req_valid_i = 1'b0;
        n_vec++;
        if (starts != MAXO) begin
            n_err++;
            $display("FAIL os_limit: got %0d want %0d", starts, MAXO);
        end
        starts = 0;
        for (int c = 0; c < 4; c++) begin
            bus.read_done_i = c == 0;
            settle();
            n_vec++;
            if (bus.read_start_o !== (c == 1)) begin
                n_err++;
                $display("FAIL os_release c%0d: got %b want %b",
                         c, bus.read_start_o, c == 1);
            end
            if (bus.read_start_o === 1'b1) starts++;
            advance();
        end
        n_vec++;
        if (starts != 1) begin
            n_err++;
            $display("FAIL os_one_more: got %0d want 1", starts);
        end
        bus.read_done_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            settle();
            n_vec++;
            if (bus.read_start_o !== e_rstart) begin
                n_err++;
                $display("FAIL os_drain c%0d: got %b want %b",
                         c, bus.read_start_o, e_rstart);
            end
            advance();
        end
        bus.read_done_i = 1'b0;
        settle();
        n_vec++;
        if (bus.idle_o !== 1'b1) begin
            n_err++;
            $display("FAIL os_idle: got %b want 1", bus.idle_o);
        end
        advance();
    endtask

    task automatic test_flush();
        int starts = 0;
        idle_inputs();
        for (int c = 0; c < 7; c++) begin
            bus.wr_req_valid_i   = 1'b1;
            bus.wr_req_address_i = 32'h3000 + 32'(c * 4);
            bus.wr_req_data_i    = 32'(c);
            bus.wr_req_strobe_i  = 4'hF;
            bus.rd_req_valid_i   = c == 0;
            bus.rd_req_address_i = 32'h4444;
            advance();
        end
        idle_inputs();
        bus.write_cts_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            n_vec++;
            if (bus.write_start_o !== 1'b1) begin
                n_err++;
                $display("FAIL flush_pre_start c%0d: got %b want 1",
                         c, bus.write_start_o);
            end
            advance();
        end
        bus.write_done_i     = 1'b1;
        bus.write_response_i = 2'b10;
        bus.wr_req_valid_i   = 1'b1;
        settle();
        n_vec += 2;
        if (bus.write_start_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_edge_start: got %b want 0", bus.write_start_o);
        end
        if (bus.wr_req_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_edge_ready: got %b want 0", bus.wr_req_ready_o);
        end
        advance();
        idle_inputs();
        bus.write_cts_i = 1'b1;
        settle();
        n_vec += 4;
        if (bus.wr_ack_o !== 1'b1 || bus.wr_error_o !== 1'b1) begin
            n_err++;
            $display("FAIL flush_ack: got %b%b want 11",
                     bus.wr_ack_o, bus.wr_error_o);
        end
        if (bus.write_start_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_empty: got %b want 0", bus.write_start_o);
        end
        if (bus.idle_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_idle: got %b want 0", bus.idle_o);
        end
        if (bus.read_start_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_rd_start: got %b want 0", bus.read_start_o);
        end
        advance();
        // One write still outstanding, so only three more may issue.
        for (int c = 0; c < 10; c++) begin
            bus.wr_req_valid_i   = c < 5;
            bus.wr_req_address_i = 32'h5000 + 32'(c * 4);
            settle();
            n_vec++;
            if (bus.write_start_o !== e_wstart) begin
                n_err++;
                $display("FAIL flush_reissue c%0d: got %b want %b",
                         c, bus.write_start_o, e_wstart);
            end
            if (bus.write_start_o === 1'b1) starts++;
            advance();
        end
        n_vec++;
        if (starts != MAXO - 1) begin
            n_err++;
            $display("FAIL flush_outstanding: got %0d want %0d", starts, MAXO - 1);
        end
        idle_inputs();
        bus.read_cts_i = 1'b1;
        settle();
        n_vec += 2;
        if (bus.read_start_o !== 1'b1) begin
            n_err++;
            $display("FAIL flush_rd_kept: got %b want 1", bus.read_start_o);
        end
        if (bus.read_address_o !== 32'h4444) begin
            n_err++;
            $display("FAIL flush_rd_addr: got %h want 00004444",
                     bus.read_address_o);
        end
        advance();
        idle_inputs();
        bus.write_done_i = 1'b1;
        bus.write_cts_i  = 1'b1;
        bus.read_done_i  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            settle();
            n_vec += 2;
            if (bus.write_start_o !== e_wstart) begin
                n_err++;
                $display("FAIL flush_drain c%0d: got %b want %b",
                         c, bus.write_start_o, e_wstart);
            end
            if (bus.wr_error_o !== e_werr) begin
                n_err++;
                $display("FAIL flush_drain_err c%0d: got %b want %b",
                         c, bus.wr_error_o, e_werr);
            end
            advance();
        end
        idle_inputs();
        settle();
        n_vec++;
        if (bus.idle_o !== 1'b1) begin
            n_err++;
            $display("FAIL flush_final_idle: got %b want 1", bus.idle_o);
        end
        advance();
    endtask

    task automatic test_read_data();
        logic [1:0]  resp [3];
        logic [31:0] dat  [3];
        resp[0] = 2'b00; dat[0] = 32'hDEADBEEF;
        resp[1] = 2'b11; dat[1] = 32'h12345678;
        resp[2] = 2'b10; dat[2] = 32'hCAFEF00D;
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            bus.rd_req_valid_i   = 1'b1;
            bus.rd_req_address_i = 32'h200 + 32'(k * 4);
            advance();
            idle_inputs();
            bus.read_cts_i = 1'b1;
            settle();
            n_vec += 2;
            if (bus.read_start_o !== 1'b1) begin
                n_err++;
                $display("FAIL rdat_start #%0d: got %b want 1",
                         k, bus.read_start_o);
            end
            if (bus.read_address_o !== 32'h200 + 32'(k * 4)) begin
                n_err++;
                $display("FAIL rdat_addr #%0d: got %h want %h",
                         k, bus.read_address_o, 32'h200 + 32'(k * 4));
            end
            advance();
            idle_inputs();
            bus.read_done_i     = 1'b1;
            bus.read_data_i     = dat[k];
            bus.read_response_i = resp[k];
            settle();
            n_vec++;
            if (bus.rd_req_ready_o !== (resp[k] != 2'b10)) begin
                n_err++;
                $display("FAIL rdat_ready #%0d: got %b want %b",
                         k, bus.rd_req_ready_o, resp[k] != 2'b10);
            end
            advance();
            idle_inputs();
            settle();
            n_vec += 3;
            if (bus.rd_valid_o !== 1'b1) begin
                n_err++;
                $display("FAIL rdat_valid #%0d: got %b want 1", k, bus.rd_valid_o);
            end
            if (bus.rd_data_o !== dat[k]) begin
                n_err++;
                $display("FAIL rdat_data #%0d: got %h want %h",
                         k, bus.rd_data_o, dat[k]);
            end
            if (bus.rd_error_o !== (resp[k] == 2'b10)) begin
                n_err++;
                $display("FAIL rdat_err #%0d: got %b want %b",
                         k, bus.rd_error_o, resp[k] == 2'b10);
            end
            advance();
        end
    endtask

    function automatic logic [1:0] pick_resp();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 2'b10;
        if (r == 1) return 2'b11;
        if (r == 2) return 2'b01;
        return 2'b00;
    endfunction

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst = $urandom_range(0, 299) == 0;
            bus.wr_req_valid_i   = $urandom_range(0, 1) == 1;
            bus.wr_req_address_i = $urandom;
            bus.wr_req_data_i    = $urandom;
            bus.wr_req_strobe_i  = 4'($urandom_range(0, 15));
            bus.rd_req_valid_i   = $urandom_range(0, 1) == 1;
            bus.rd_req_address_i = $urandom;
            bus.write_cts_i      = $urandom_range(0, 3) != 0;
            bus.read_cts_i       = $urandom_range(0, 3) != 0;
            bus.write_done_i     = $urandom_range(0, 2) == 0;
            bus.read_done_i      = $urandom_range(0, 2) == 0;
            bus.write_response_i = pick_resp();
            bus.read_response_i  = pick_resp();
            bus.read_data_i      = $urandom;
            settle();
            n_vec += 9;
            if (bus.wr_req_ready_o !== e_wready) begin
                n_err++;
                $display("FAIL rnd_wready c%0d: got %b want %b",
                         c, bus.wr_req_ready_o, e_wready);
            end
            if (bus.rd_req_ready_o !== e_rready) begin
                n_err++;
                $display("FAIL rnd_rready c%0d: got %b want %b",
                         c, bus.rd_req_ready_o, e_rready);
            end
            if (bus.write_start_o !== e_wstart) begin
                n_err++;
                $display("FAIL rnd_wstart c%0d: got %b want %b",
                         c, bus.write_start_o, e_wstart);
            end
            if (bus.read_start_o !== e_rstart) begin
                n_err++;
                $display("FAIL rnd_rstart c%0d: got %b want %b",
                         c, bus.read_start_o, e_rstart);
            end
            if (bus.idle_o !== e_idle) begin
                n_err++;
                $display("FAIL rnd_idle c%0d: got %b want %b",
                         c, bus.idle_o, e_idle);
            end
            if (bus.wr_ack_o !== e_wack) begin
                n_err++;
                $display("FAIL rnd_wack c%0d: got %b want %b",
                         c, bus.wr_ack_o, e_wack);
            end
            if (bus.wr_error_o !== e_werr) begin
                n_err++;
                $display("FAIL rnd_werr c%0d: got %b want %b",
                         c, bus.wr_error_o, e_werr);
            end
            if (bus.rd_valid_o !== e_rvalid) begin
                n_err++;
                $display("FAIL rnd_rvalid c%0d: got %b want %b",
                         c, bus.rd_valid_o, e_rvalid);
            end
            if (bus.rd_error_o !== e_rerr) begin
                n_err++;
                $display("FAIL rnd_rerr c%0d: got %b want %b",
                         c, bus.rd_error_o, e_rerr);
            end
            if (e_wstart) begin
                n_vec++;
                if ({bus.write_address_o, bus.write_data_o,
                     bus.write_strobe_o} !== e_whead) begin
                    n_err++;
                    $display("FAIL rnd_whead c%0d: got %h/%h/%h want %h",
                             c, bus.write_address_o, bus.write_data_o,
                             bus.write_strobe_o, e_whead);
                end
            end
            if (e_rstart) begin
                n_vec++;
                if (bus.read_address_o !== e_rhead) begin
                    n_err++;
                    $display("FAIL rnd_rhead c%0d: got %h want %h",
                             c, bus.read_address_o, e_rhead);
                end
            end
            if (e_rvalid) begin
                n_vec++;
                if (bus.rd_data_o !== e_rdata) begin
                    n_err++;
                    $display("FAIL rnd_rdata c%0d: got %h want %h",
                             c, bus.rd_data_o, e_rdata);
                end
            end
            advance();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_fill();
        test_outstanding();
        test_flush();
        test_read_data();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
